// File: rtl/bus_sram_slave_pkg.sv
// Shared types and constants for the simple-bus SRAM slave (package bus_pkg).
package bus_pkg;

    localparam int BUS_AW  = 32;
    localparam int BUS_DW  = 32;
    localparam int BUS_BEW = 4;

    // Wide enough for WAIT_STATES (0..15) plus up to 3 random extra cycles.
    localparam int WAIT_CNT_W = 5;

    // 8-bit Fibonacci LFSR, taps 8,6,5,4 -> state bits 7,5,4,3.
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    function automatic logic lfsr_feedback(input logic [7:0] state);
        return ^(state & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/bus_sram_slave_if.sv
// Simple-bus request/response bundle between the bus adapter and the SRAM slave.
interface bus_sram_slave_if;
    import bus_pkg::*;

    logic                 i_bus_en;
    logic                 i_wr_en;
    logic [BUS_AW-1:0]    i_addr;
    logic [BUS_DW-1:0]    i_wr_data;
    logic [BUS_BEW-1:0]   i_byte_en;
    logic                 o_ack;
    logic [BUS_DW-1:0]    o_rd_data;

    modport master (
        output i_bus_en, i_wr_en, i_addr, i_wr_data, i_byte_en,
        input  o_ack, o_rd_data
    );

    modport slave (
        input  i_bus_en, i_wr_en, i_addr, i_wr_data, i_byte_en,
        output o_ack, o_rd_data
    );

endinterface

// File: rtl/bus_sram_slave_sram_byte_array.sv
// Word-organised synchronous RAM built as four independent byte lanes,
// each with its own write enable and a registered read with sync clear.
module sram_byte_array
    import bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic                i_clk,
    input  logic [IDX_W-1:0]    i_addr,
    input  logic [BUS_BEW-1:0]  i_we,
    input  logic [BUS_DW-1:0]   i_wr_data,
    input  logic                i_rd_en,
    input  logic                i_rd_clr,
    output logic [BUS_DW-1:0]   o_rd_data
);

    genvar gi;
    generate
        for (gi = 0; gi < BUS_BEW; gi++) begin : g_lane
            logic [7:0] mem_lane [DEPTH_WORDS];
            logic [7:0] rd_lane_q;

            // One byte lane: write port plus registered read with clear.
            always_ff @(posedge i_clk) begin
                if (i_we[gi]) begin
                    mem_lane[i_addr] <= i_wr_data[8*gi +: 8];
                end
                if (i_rd_clr) begin
                    rd_lane_q <= '0;
                end else if (i_rd_en) begin
                    rd_lane_q <= mem_lane[i_addr];
                end
            end

            assign o_rd_data[8*gi +: 8] = rd_lane_q;
        end
    endgenerate

endmodule

// File: rtl/bus_sram_slave.sv
// Simple-bus SRAM slave: request capture, programmable wait states, one-cycle
// ack. Optional macro ARVI_SRAM_RAND_WAIT_EN adds 0..3 LFSR-driven extra waits.
module bus_sram_slave
    import bus_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    bus_sram_slave_if.slave bus
);

    localparam int          IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) * 33'd4;

    state_t                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [WAIT_CNT_W-1:0]   eff_wait;
    logic                    capture;
    logic                    enter_ack;

    // Latched request, used for every cycle after capture.
    logic [IDX_W-1:0]        req_idx_q;
    logic                    req_in_range_q;
    logic                    req_wr_q;
    logic [BUS_DW-1:0]       req_data_q;
    logic [BUS_BEW-1:0]      req_be_q;

    // Decode of the live bus address.
    logic [BUS_AW-1:0]       offset_bus;
    logic [IDX_W-1:0]        idx_bus;
    logic                    in_range_bus;

    assign offset_bus   = bus.i_addr - BASE_ADDR;
    assign idx_bus      = offset_bus[IDX_W+1:2];
    assign in_range_bus = ({1'b0, offset_bus} < SPAN);

`ifdef ARVI_SRAM_RAND_WAIT_EN
    logic [7:0] lfsr_q;

    // Free-running LFSR that randomises extra wait cycles per request.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_feedback(lfsr_q)};
        end
    end

    assign eff_wait = WAIT_CNT_W'(WAIT_STATES) + WAIT_CNT_W'(lfsr_q[1:0]);
`else
    assign eff_wait = WAIT_CNT_W'(WAIT_STATES);
`endif

    // Next-state logic: capture in IDLE, count down in WAIT, single ACK cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture   = 1'b0;
        enter_ack = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.i_bus_en) begin
                    capture = 1'b1;
                    if (eff_wait == '0) begin
                        state_d   = ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = eff_wait;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= WAIT_CNT_W'(1)) begin
                    state_d   = ACK;
                    enter_ack = 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and wait counter registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request latch; later bus changes are ignored until the next IDLE.
    always_ff @(posedge i_clk) begin
        if (capture) begin
            req_idx_q      <= idx_bus;
            req_in_range_q <= in_range_bus;
            req_wr_q       <= bus.i_wr_en;
            req_data_q     <= bus.i_wr_data;
            req_be_q       <= bus.i_byte_en;
        end
    end

    // With zero wait states the memory access happens on the capture edge,
    // so the RAM port takes the live bus fields while still in IDLE.
    logic                 use_bus;
    logic [IDX_W-1:0]     sel_idx;
    logic                 sel_in_range;
    logic                 sel_wr;
    logic [BUS_DW-1:0]    sel_data;
    logic [BUS_BEW-1:0]   sel_be;
    logic [BUS_BEW-1:0]   ram_we;
    logic                 ram_rd_en;
    logic                 ram_rd_clr;

    assign use_bus      = (state_q == IDLE);
    assign sel_idx      = use_bus ? idx_bus         : req_idx_q;
    assign sel_in_range = use_bus ? in_range_bus    : req_in_range_q;
    assign sel_wr       = use_bus ? bus.i_wr_en     : req_wr_q;
    assign sel_data     = use_bus ? bus.i_wr_data   : req_data_q;
    assign sel_be       = use_bus ? bus.i_byte_en   : req_be_q;

    // Reset suppresses a commit; out-of-range reads clear the read register.
    assign ram_we     = {BUS_BEW{enter_ack & sel_wr & sel_in_range & i_rst}} & sel_be;
    assign ram_rd_en  = enter_ack & ~sel_wr;
    assign ram_rd_clr = ~i_rst | (enter_ack & ~sel_wr & ~sel_in_range);

    sram_byte_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_ram (
        .i_clk     (i_clk),
        .i_addr    (sel_idx),
        .i_we      (ram_we),
        .i_wr_data (sel_data),
        .i_rd_en   (ram_rd_en),
        .i_rd_clr  (ram_rd_clr),
        .o_rd_data (bus.o_rd_data)
    );

    assign bus.o_ack = (state_q == ACK);

    // The master must keep its request asserted while the slave is waiting.
    a_req_held: assert property (
        @(posedge i_clk) disable iff (!i_rst) (state_q == WAIT) |-> bus.i_bus_en
    ) else $error("bus_sram_slave: request withdrawn during WAIT");

endmodule
